// File: rtl/int_dispatch_queue.sv
// int_dispatch_queue: in-order circular queue between rename and the integer block.
// Compacts sparse enqueue lanes and presents the oldest OUTWID entries for prefix dispatch.
`ifndef INTDQ_DISP_WID
`define INTDQ_DISP_WID 4
`endif

module int_dispatch_queue #(
    parameter int DEPTH          = 16,
    parameter int INWID          = 4,
    parameter int OUTWID         = `INTDQ_DISP_WID,
    parameter int UOPW           = 32,
    parameter int RDY_PREFIX_CHK = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [INWID-1:0]         enq_req,
    output logic                     enq_rdy,
    input  logic [INWID*UOPW-1:0]    enq_info,
    output logic [OUTWID-1:0]        int_req,
    input  logic [OUTWID-1:0]        int_rdy,
    output logic [OUTWID*UOPW-1:0]   int_info,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]             rp_q, rp_d, wp_q, wp_d;
    logic [CW-1:0]             count_q, count_d, nenq, ndeq;
    logic [UOPW-1:0]           mem_q [DEPTH];
    logic [INWID-1:0]          acc;
    logic [INWID-1:0][PW-1:0]  woff;
    logic [OUTWID-1:0]         fire;
    logic                      run;

    assign enq_rdy = !flush && (count_q <= CW'(DEPTH - INWID));
    assign count   = count_q;

    // Accepted lanes are packed into consecutive slots starting at wp.
    always_comb begin
        nenq = '0;
        acc  = '0;
        woff = '0;
        for (int i = 0; i < INWID; i++) begin
            acc[i]  = enq_rdy && enq_req[i];
            woff[i] = wp_q + PW'(nenq);
            nenq    = nenq + CW'(acc[i]);
        end
    end

    for (genvar g = 0; g < OUTWID; g++) begin : g_lane
        assign int_req[g]              = !flush && (CW'(g) < count_q);
        assign int_info[g*UOPW +: UOPW] = mem_q[AW'(rp_q + PW'(g))];
    end

    // Only the leading run of accepted lanes leaves the queue.
    always_comb begin
        fire = int_req & int_rdy;
        ndeq = '0;
        run  = 1'b1;
        for (int i = 0; i < OUTWID; i++) begin
            run  = run & fire[i];
            ndeq = ndeq + CW'(run);
        end
    end

    always_comb begin
        rp_d    = flush ? '0 : rp_q + PW'(ndeq);
        wp_d    = flush ? '0 : wp_q + PW'(nenq);
        count_d = flush ? '0 : count_q + nenq - ndeq;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rp_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < INWID; i++)
            if (acc[i]) mem_q[woff[i][AW-1:0]] <= enq_info[i*UOPW +: UOPW];
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (count_q <= CW'(DEPTH))
                else $error("int_dispatch_queue: count %0d exceeds depth", count_q);
            assert (PW'(wp_q - rp_q) == PW'(count_q))
                else $error("int_dispatch_queue: pointer distance disagrees with count");
            if (RDY_PREFIX_CHK != 0 && int_req != '0)
                assert ((int_rdy & (int_rdy + OUTWID'(1))) == '0)
                    else $error("int_dispatch_queue: int_rdy %b is not a prefix mask", int_rdy);
        end
    end
`endif
endmodule

// File: tb/tb_int_dispatch_queue.sv
// tb_int_dispatch_queue: directed and random checks of int_dispatch_queue against a queue model.
module tb_int_dispatch_queue;
    localparam int DEPTH = 16, INWID = 4, OUTWID = 4, UOPW = 16;
    localparam int CW = $clog2(DEPTH + 1);

    logic                    clk = 1'b0, rst = 1'b0, flush = 1'b0;
    logic [INWID-1:0]        enq_req = '0;
    logic                    enq_rdy;
    logic [INWID*UOPW-1:0]   enq_info = '0;
    logic [OUTWID-1:0]       int_req;
    logic [OUTWID-1:0]       int_rdy = '0;
    logic [OUTWID*UOPW-1:0]  int_info;
    logic [CW-1:0]           count;

    int checks = 0, fails = 0;
    logic [UOPW-1:0] q[$];
    logic [UOPW-1:0] seq = 16'h0001;
    logic [UOPW-1:0] s0;

    always #5 clk = ~clk;

    int_dispatch_queue #(.DEPTH(DEPTH), .INWID(INWID), .OUTWID(OUTWID), .UOPW(UOPW),
                         .RDY_PREFIX_CHK(0)) dut (
        .clk(clk), .rst(rst), .flush(flush), .enq_req(enq_req), .enq_rdy(enq_rdy),
        .enq_info(enq_info), .int_req(int_req), .int_rdy(int_rdy), .int_info(int_info),
        .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fresh sequence numbers go to requested lanes only, so output order is easy to trace.
    task automatic load(input logic [INWID-1:0] req);
        enq_req = req;
        for (int i = 0; i < INWID; i++) begin
            enq_info[i*UOPW +: UOPW] = req[i] ? seq : UOPW'(16'hD000 + i);
            if (req[i]) seq++;
        end
    endtask

    task automatic cycle();
        logic [OUTWID-1:0] er;
        int n;
        bit run, acc;
        @(negedge clk);
        chk("count", count, q.size());
        chk("enq_rdy", enq_rdy, !flush && q.size() <= DEPTH - INWID);
        er = '0;
        for (int i = 0; i < OUTWID; i++) er[i] = !flush && i < q.size();
        chk("int_req", int_req, er);
        for (int i = 0; i < OUTWID; i++)
            if (er[i]) chk($sformatf("int_info[%0d]", i), int_info[i*UOPW +: UOPW], q[i]);
        if (!rst || flush) q.delete();
        else begin
            acc = q.size() <= DEPTH - INWID;
            n = 0;
            run = 1'b1;
            for (int i = 0; i < OUTWID; i++) begin
                run = run && er[i] && int_rdy[i];
                if (run) n++;
            end
            repeat (n) void'(q.pop_front());
            if (acc)
                for (int i = 0; i < INWID; i++)
                    if (enq_req[i]) q.push_back(enq_info[i*UOPW +: UOPW]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_enq_rdy", enq_rdy, 1);

        s0 = seq;
        load(4'b1011);
        cycle();
        load(4'b0000);
        chk("sparse_req", int_req, 4'b0111);
        chk("sparse_lane2", int_info[2*UOPW +: UOPW], s0 + 16'd2);
        cycle();

        int_rdy = '1;
        cycle();
        int_rdy = '0;
        repeat (5) begin
            load(4'b1111);
            cycle();
        end
        load(4'b0000);
        chk("full_count", count, 16);
        chk("full_enq_rdy", enq_rdy, 0);
        chk("full_req", int_req, 4'b1111);
        cycle();

        int_rdy = '1;
        repeat (3) cycle();
        int_rdy = 4'b1101;
        s0 = q[1];
        cycle();
        int_rdy = '0;
        chk("partial_count", count, 3);
        chk("partial_lane0", int_info[UOPW-1:0], s0);
        cycle();

        int_rdy = '1;
        cycle();
        int_rdy = '0;
        load(4'b1111); cycle();
        load(4'b1111); cycle();
        load(4'b0011); cycle();
        chk("pre_flush_count", count, 10);
        load(4'b1111);
        int_rdy = '1;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        int_rdy = '0;
        chk("flush_count", count, 0);
        s0 = seq;
        load(4'b0100);
        cycle();
        load(4'b0000);
        chk("post_flush_lane0", int_info[UOPW-1:0], s0);
        cycle();

        load(4'b1111); cycle();
        load(4'b0111); cycle();
        load(4'b0000);
        chk("pre_rst_count", count, 8);
        int_rdy = 4'b0001;
        cycle();
        int_rdy = '0;
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("mid_rst_req", int_req, 0);
        cycle();

        repeat (300) begin
            load(INWID'($urandom));
            int_rdy = OUTWID'((1 << $urandom_range(0, OUTWID)) - 1);
            cycle();
        end
        load(4'b0000);
        int_rdy = '1;
        repeat (6) cycle();
        chk("drained_count", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
